// File: rtl/reset_request_gen.sv
// Reset request generator.
// Merges a debounced pushbutton, a software strobe and a watchdog into one
// stretched, registered reset request with a sticky cause code. Clocked by the
// free-running board clock and reset only by the board reset, so it keeps
// running through the resets it requests.
module reset_request_gen #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WDT_CYCLES      = 2**20,
  parameter int REQ_CYCLES      = 8,
  parameter int HOLDOFF_CYCLES  = 16
) (
  input  logic       I_CLK,
  input  logic       I_ASYNC_RESET,
  input  logic       I_BUTTON,
  input  logic       I_SW_RESET,
  input  logic       I_WDT_ENABLE,
  input  logic       I_WDT_KICK,
  output logic       O_RESET_REQ,
  output logic [1:0] O_CAUSE,
  output logic       O_BUSY
);

  localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int WDT_W     = $clog2(WDT_CYCLES);
  localparam int PHASE_MAX = (REQ_CYCLES > HOLDOFF_CYCLES) ? REQ_CYCLES : HOLDOFF_CYCLES;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_ZERO   = {DEB_W{1'b0}};
  localparam logic [WDT_W-1:0]   WDT_RELOAD = WDT_W'(WDT_CYCLES - 1);
  localparam logic [WDT_W-1:0]   WDT_ZERO   = {WDT_W{1'b0}};
  localparam logic [PHASE_W-1:0] REQ_LOAD   = PHASE_W'(REQ_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LOAD  = PHASE_W'(HOLDOFF_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_ZERO = {PHASE_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_BUTTON = 2'd1,
    CAUSE_SW     = 2'd2,
    CAUSE_WDT    = 2'd3
  } cause_e;

  // Button synchronizer and debouncer
  logic             btn_meta_r;
  logic             btn_sync_r;
  logic             deb_level_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic             deb_flip_s;
  logic             btn_event_s;

  // Watchdog
  logic [WDT_W-1:0] wdt_cnt_r;
  logic             wdt_hold_s;
  logic             wdt_event_s;

  // One-cycle event stage between the sources and the FSM
  logic             ev_btn_r;
  logic             ev_sw_r;
  logic             ev_wdt_r;

  // Request FSM
  state_e           state_r;
  state_e           state_nxt_s;
  logic [PHASE_W-1:0] phase_cnt_r;
  logic [PHASE_W-1:0] phase_cnt_nxt_s;
  cause_e           cause_r;
  cause_e           cause_nxt_s;
  logic             req_r;
  logic             busy_r;

  // Two-flop synchronizer for the asynchronous pushbutton
  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
    end else begin
      btn_meta_r <= I_BUTTON;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Debounce flip condition; only a rising debounced edge is a button event
  always_comb begin
    deb_flip_s  = 1'b0;
    btn_event_s = 1'b0;
    if ((btn_sync_r != deb_level_r) && (deb_cnt_r == DEB_LAST)) begin
      deb_flip_s = 1'b1;
    end else begin
      deb_flip_s = 1'b0;
    end
    btn_event_s = deb_flip_s & ~deb_level_r;
  end

  // Debounce counter and level; keeps tracking even while a request is busy
  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      deb_level_r <= 1'b0;
      deb_cnt_r   <= DEB_ZERO;
    end else if (btn_sync_r == deb_level_r) begin
      deb_cnt_r   <= DEB_ZERO;
    end else if (deb_flip_s) begin
      deb_level_r <= ~deb_level_r;
      deb_cnt_r   <= DEB_ZERO;
    end else begin
      deb_cnt_r   <= deb_cnt_r + 1'b1;
    end
  end

  // Watchdog expiry: a kick on the zero count wins; frozen while a request is pending or busy
  always_comb begin
    wdt_hold_s  = 1'b0;
    wdt_event_s = 1'b0;
    if ((state_r != ST_IDLE) || ev_btn_r || ev_sw_r || ev_wdt_r) begin
      wdt_hold_s = 1'b1;
    end else begin
      wdt_hold_s = 1'b0;
    end
    wdt_event_s = I_WDT_ENABLE & ~I_WDT_KICK & ~wdt_hold_s & (wdt_cnt_r == WDT_ZERO);
  end

  // Watchdog down-counter with reload on disable, kick, hold or expiry
  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      wdt_cnt_r <= WDT_RELOAD;
    end else if (!I_WDT_ENABLE || I_WDT_KICK || wdt_hold_s || wdt_event_s) begin
      wdt_cnt_r <= WDT_RELOAD;
    end else begin
      wdt_cnt_r <= wdt_cnt_r - 1'b1;
    end
  end

  // Register the event pulses; the FSM only honours them in IDLE, so busy-time events are dropped
  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      ev_btn_r <= 1'b0;
      ev_sw_r  <= 1'b0;
      ev_wdt_r <= 1'b0;
    end else begin
      ev_btn_r <= btn_event_s;
      ev_sw_r  <= I_SW_RESET;
      ev_wdt_r <= wdt_event_s;
    end
  end

  // FSM next state, phase counter and cause selection (watchdog > button > software)
  always_comb begin
    state_nxt_s     = state_r;
    phase_cnt_nxt_s = phase_cnt_r;
    cause_nxt_s     = cause_r;
    case (state_r)
      ST_IDLE: begin
        if (ev_wdt_r || ev_btn_r || ev_sw_r) begin
          state_nxt_s     = ST_ASSERT;
          phase_cnt_nxt_s = REQ_LOAD;
          if (ev_wdt_r) begin
            cause_nxt_s = CAUSE_WDT;
          end else if (ev_btn_r) begin
            cause_nxt_s = CAUSE_BUTTON;
          end else begin
            cause_nxt_s = CAUSE_SW;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (phase_cnt_r == PHASE_ZERO) begin
          state_nxt_s     = ST_HOLDOFF;
          phase_cnt_nxt_s = HOLD_LOAD;
        end else begin
          phase_cnt_nxt_s = phase_cnt_r - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (phase_cnt_r == PHASE_ZERO) begin
          state_nxt_s = ST_IDLE;
        end else begin
          phase_cnt_nxt_s = phase_cnt_r - 1'b1;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        phase_cnt_nxt_s = PHASE_ZERO;
      end
    endcase
  end

  // FSM state and registered outputs decoded from the next state
  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      state_r     <= ST_IDLE;
      phase_cnt_r <= PHASE_ZERO;
      cause_r     <= CAUSE_NONE;
      req_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      phase_cnt_r <= phase_cnt_nxt_s;
      cause_r     <= cause_nxt_s;
      req_r       <= (state_nxt_s == ST_ASSERT);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign O_RESET_REQ = req_r;
  assign O_CAUSE     = cause_r;
  assign O_BUSY      = busy_r;

endmodule

// File: tb/tb_reset_request_gen.sv
// Directed self-checking bench for reset_request_gen with small parameters.
module tb_reset_request_gen;

  logic       I_CLK = 1'b0;
  logic       I_ASYNC_RESET = 1'b1;
  logic       I_BUTTON = 1'b0;
  logic       I_SW_RESET = 1'b0;
  logic       I_WDT_ENABLE = 1'b0;
  logic       I_WDT_KICK = 1'b0;
  logic       O_RESET_REQ;
  logic [1:0] O_CAUSE;
  logic       O_BUSY;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulses  = 0;
  int last_rise = -1;
  logic req_q = 1'b0;

  reset_request_gen #(
    .DEBOUNCE_CYCLES(4),
    .WDT_CYCLES(20),
    .REQ_CYCLES(3),
    .HOLDOFF_CYCLES(5)
  ) dut (
    .I_CLK(I_CLK),
    .I_ASYNC_RESET(I_ASYNC_RESET),
    .I_BUTTON(I_BUTTON),
    .I_SW_RESET(I_SW_RESET),
    .I_WDT_ENABLE(I_WDT_ENABLE),
    .I_WDT_KICK(I_WDT_KICK),
    .O_RESET_REQ(O_RESET_REQ),
    .O_CAUSE(O_CAUSE),
    .O_BUSY(O_BUSY)
  );

  // Free-running clock
  always #5 I_CLK = ~I_CLK;

  // Count rising clock edges
  always @(posedge I_CLK) cyc <= cyc + 1;

  // Count request pulses and record the edge index of each rise
  always @(negedge I_CLK) begin
    if (O_RESET_REQ && !req_q) begin
      pulses    <= pulses + 1;
      last_rise <= cyc;
    end
    req_q <= O_RESET_REQ;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  initial begin
    int c;
    int p;
    int k;

    // Reset state
    repeat (3) tick();
    check("rst_req", O_RESET_REQ, 0);
    check("rst_busy", O_BUSY, 0);
    check("rst_cause", O_CAUSE, 0);
    I_ASYNC_RESET = 1'b0;
    repeat (3) tick();

    // Software strobe, second strobe 4 cycles later ignored
    p = pulses;
    I_SW_RESET = 1'b1;
    tick();
    I_SW_RESET = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4) I_SW_RESET = 1'b0;
      check($sformatf("sw_req_%0d", i), O_RESET_REQ, (i <= 3) ? 1 : 0);
      check($sformatf("sw_busy_%0d", i), O_BUSY, (i <= 8) ? 1 : 0);
      if (i == 1) check("sw_cause", O_CAUSE, 2);
      if (i == 3) I_SW_RESET = 1'b1;
    end
    repeat (5) tick();
    check("sw_pulses", pulses - p, 1);

    // Asynchronous reset in the middle of ASSERT
    I_SW_RESET = 1'b1;
    tick();
    I_SW_RESET = 1'b0;
    tick();
    check("mid_req_before", O_RESET_REQ, 1);
    I_ASYNC_RESET = 1'b1;
    #1;
    check("mid_req", O_RESET_REQ, 0);
    check("mid_busy", O_BUSY, 0);
    check("mid_cause", O_CAUSE, 0);
    repeat (2) tick();
    I_ASYNC_RESET = 1'b0;
    p = pulses;
    repeat (15) tick();
    check("mid_no_pulse", pulses - p, 0);

    // Bouncing button, then held: one request 7 cycles after final rise
    p = pulses;
    for (int b = 0; b < 4; b++) begin
      I_BUTTON = (b % 2 == 0) ? 1'b1 : 1'b0;
      repeat (2) tick();
    end
    k = cyc;
    I_BUTTON = 1'b1;
    repeat (30) tick();
    check("btn_pulses", pulses - p, 1);
    check("btn_rise", last_rise, k + 7);
    check("btn_cause", O_CAUSE, 1);
    I_BUTTON = 1'b0;
    repeat (20) tick();
    check("btn_release", pulses - p, 1);

    // Watchdog kicked every 15 cycles, then left to expire
    p = pulses;
    I_WDT_ENABLE = 1'b1;
    for (int i = 0; i < 200; i++) begin
      I_WDT_KICK = (i % 15 == 0) ? 1'b1 : 1'b0;
      tick();
      if (i == 195) k = cyc;
    end
    I_WDT_KICK = 1'b0;
    check("wdt_kicked", pulses - p, 0);
    repeat (21) tick();
    check("wdt_pulses", pulses - p, 1);
    check("wdt_rise", last_rise, k + 21);
    check("wdt_cause", O_CAUSE, 3);
    I_WDT_ENABLE = 1'b0;
    repeat (12) tick();

    // Kick exactly on count 0 suppresses expiry; next expiry one full period later
    p = pulses;
    c = cyc;
    I_WDT_ENABLE = 1'b1;
    repeat (19) tick();
    I_WDT_KICK = 1'b1;
    tick();
    I_WDT_KICK = 1'b0;
    repeat (25) tick();
    check("kick0_pulses", pulses - p, 1);
    check("kick0_rise", last_rise, c + 41);
    I_WDT_ENABLE = 1'b0;
    repeat (12) tick();

    // Software strobe together with a debounced button edge
    p = pulses;
    k = cyc;
    I_BUTTON = 1'b1;
    repeat (5) tick();
    I_SW_RESET = 1'b1;
    tick();
    I_SW_RESET = 1'b0;
    repeat (4) tick();
    check("swbtn_rise", last_rise, k + 7);
    check("swbtn_cause", O_CAUSE, 1);
    repeat (15) tick();
    I_BUTTON = 1'b0;
    repeat (20) tick();
    check("swbtn_pulses", pulses - p, 1);

    // Software strobe together with watchdog expiry
    p = pulses;
    c = cyc;
    I_WDT_ENABLE = 1'b1;
    repeat (19) tick();
    I_SW_RESET = 1'b1;
    tick();
    I_SW_RESET = 1'b0;
    tick();
    I_WDT_ENABLE = 1'b0;
    repeat (14) tick();
    check("swwdt_pulses", pulses - p, 1);
    check("swwdt_rise", last_rise, c + 21);
    check("swwdt_cause", O_CAUSE, 3);

    // Button pressed and held through a software-triggered busy window
    p = pulses;
    c = cyc;
    I_SW_RESET = 1'b1;
    tick();
    I_SW_RESET = 1'b0;
    I_BUTTON = 1'b1;
    repeat (40) tick();
    check("hold_pulses", pulses - p, 1);
    check("hold_rise", last_rise, c + 2);
    check("hold_cause", O_CAUSE, 2);
    I_BUTTON = 1'b0;
    repeat (10) tick();
    check("hold_release", pulses - p, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
